game_ctrl: RTL and testbench
============================

# game_ctrl

Blackjack game sequencer. Runs the round flow (menu, initial deal, player turn, dealer turn, result), requests cards from the deck/hand block over a req/ack handshake, and judges the hands. Publishes a 3-bit `state` to the draw chain (draw_menu and the table/card drawers). `state` changes only at frame start, so the picture never switches mid-frame.

## Interface
- `RESULT_FRAMES`, default 180: frames spent in RESULT before auto-return to MENU (180 frames is about 3 s at 60 Hz).
- `DEALER_STAND`, default 17: the dealer draws while `dealer_sum` is below this value.

Ports:
- `clk`, in, 1: pixel/system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `vblnk`, in, 1: vertical blank from the VGA timing chain. Its rising edge is the frame tick.
- `btn_start`, in, 1: debounced level.
- `btn_hit`, in, 1: debounced level.
- `btn_stand`, in, 1: debounced level.
- `player_sum`, in, 5: player hand value, aces already resolved.
- `dealer_sum`, in, 5: dealer hand value, aces already resolved.
- `deal_ack`, in, 1: one-cycle pulse from the deck block; the card has been added to the target hand.
- `deal_req`, out, 1: card request, held until `deal_ack`.
- `deal_to_dealer`, out, 1: target hand for the current request (0 = player, 1 = dealer). Stable while `deal_req` is high.
- `hand_clr`, out, 1: one-cycle pulse that clears both hands at round start.
- `state`, out, 3: displayed state. 0 MENU, 1 DEAL, 2 PLAYER, 3 DEALER, 4 RESULT.
- `result`, out, 2: 0 none, 1 player win, 2 player lose, 3 push. Valid while `state` = 4.

## Operation
- Button rising edges are detected internally (1-cycle delayed copy) and latched as sticky `start_ev`, `hit_ev` and `stand_ev` flags.
- The FSM consumes flags only in the states listed below. Every flag is cleared on any FSM state change.
- Internal FSM states: MENU, CLR, DEAL_REQ, DEAL_WAIT, SETTLE, PLAYER, DEALER, RESULT.
- **MENU**:
  - `result` = 0.
  - On `start_ev`: go to CLR.
- **CLR**:
  - Assert `hand_clr` for 1 cycle.
  - Set deal count to 0.
  - Go to DEAL_REQ.
- **DEAL_REQ**:
  - Assert `deal_req`.
  - During the initial deal, target follows deal count: 0 player, 1 dealer, 2 player, 3 dealer.
  - Go to DEAL_WAIT.
- **DEAL_WAIT**:
  - Hold `deal_req` and target until `deal_ack`.
  - On `deal_ack`: drop `deal_req` the next cycle and go to SETTLE. Sums are valid from the cycle after ack.
- **SETTLE**, one cycle, then branch:
  - Initial deal, count < 3: increment count, go to DEAL_REQ.
  - Initial deal, count = 3: go to PLAYER.
  - Player hit: go to PLAYER.
  - Dealer draw: go to DEALER.
- **PLAYER**:
  - `player_sum` > 21: result lose, go to RESULT.
  - Else if `player_sum` = 21: go to DEALER automatically.
  - Else if `hit_ev`: request a player card.
  - Else if `stand_ev`: go to DEALER.
  - If `hit_ev` and `stand_ev` are both set in the same cycle, hit wins.
- **DEALER**:
  - If `dealer_sum` < `DEALER_STAND`: request a dealer card.
  - Otherwise judge:
    - `dealer_sum` > 21, or `player_sum` > `dealer_sum`: win.
    - `player_sum` = `dealer_sum`: push.
    - Otherwise: lose.
  - Then go to RESULT.
- **RESULT**:
  - Frame counter starts at 0 on entry and increments on each frame tick.
  - At count `RESULT_FRAMES`, or on `start_ev`, go to MENU.
  - A `start_ev` here returns to MENU only; it does not start a new round.
- **Display state mapping**:
  - MENU → 0.
  - CLR, DEAL_REQ, DEAL_WAIT and SETTLE during the initial deal → 1.
  - PLAYER, and player-hit deal states → 2.
  - DEALER, and dealer-draw deal states → 3.
  - RESULT → 4.
- The `state` output register loads the mapped value only on a frame tick.
- `result` is registered when RESULT is entered and cleared on entry to MENU.
- Sums are 5-bit unsigned; values up to 31 are legal, and any value above 21 is a bust.

## Timing
- **Reset** (asynchronous): `state`=0, `result`=0, `deal_req`=0, `deal_to_dealer`=0, `hand_clr`=0. FSM goes to MENU; flags, counters and the vblnk delay register go to 0.
- Button press to flag: 1 cycle after the rising edge is sampled.
- MENU to `hand_clr`: 1 cycle after the flag. `deal_req` rises the cycle after `hand_clr`.
- `deal_ack` may arrive in the same cycle `deal_req` rises; it is honored.
- A `deal_ack` while `deal_req` is low is ignored.
- Frame tick: `vblnk` high and its 1-cycle-delayed copy low. `state` updates the cycle after the tick.
- If the FSM passes through several states within one frame, only the value mapped at the tick is shown.
- Reset during a handshake drops `deal_req` immediately. The deck block must tolerate an abandoned request.

## Test plan
- **Reset/idle:** hold `rst` mid-deal → `deal_req`=0, `state`=0, `result`=0 at once; with no buttons pressed, the block stays in MENU indefinitely.
- **Full deal and frame sync:**
  - Stimulus: `btn_start` pulse; ack each request after 3 cycles.
  - Required: one `hand_clr` pulse; 4 requests with targets 0,1,0,1.
  - Required: `state` reads 1 only after the next `vblnk` rise, then 2.
- **Player bust:**
  - Stimulus: `player_sum`=15, then `btn_hit`; ack; `player_sum`=25.
  - Required: `result`=2 and `state`=4 on the next frame; no dealer requests.
- **Dealer draws then busts:**
  - Stimulus: `btn_stand` with `player_sum`=18, `dealer_sum`=12.
  - Required: one dealer request; after ack with `dealer_sum`=22, `result`=1.
- **Push and simultaneous buttons:**
  - Stimulus: `btn_hit` and `btn_stand` rise in the same cycle with `player_sum`=10.
  - Required: a player card is requested (hit wins).
  - Then: with sums 19/19 after stand, `result`=3.
- **Result timeout:**
  - Stimulus: `RESULT_FRAMES`=3.
  - Required: MENU (`state`=0, `result`=0) shown 1 frame after the 3rd tick following RESULT entry, since `state` updates on the next tick after the return to MENU.
  - Required: `btn_start` during RESULT returns to MENU early and does not start a deal.

Source files
------------

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - Blackjack round sequencer: deal handshake, hand judging, frame-synced display state
// The FSM runs at clock rate; only the published state register is tied to the frame tick.
module game_ctrl #(
  parameter int unsigned RESULT_FRAMES = 180,
  parameter int unsigned DEALER_STAND  = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       btn_start,
  input  logic       btn_hit,
  input  logic       btn_stand,
  input  logic [4:0] player_sum,
  input  logic [4:0] dealer_sum,
  input  logic       deal_ack,
  output logic       deal_req,
  output logic       deal_to_dealer,
  output logic       hand_clr,
  output logic [2:0] state,
  output logic [1:0] result
);

  localparam int unsigned   FW         = (RESULT_FRAMES < 2) ? 1 : $clog2(RESULT_FRAMES + 1);
  localparam logic [FW-1:0] FRAMES_END = FW'(RESULT_FRAMES);
  localparam logic [4:0]    STAND_SUM  = 5'(DEALER_STAND);
  localparam logic [4:0]    BLACKJACK  = 5'd21;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_LOSE = 2'd2;
  localparam logic [1:0] RES_PUSH = 2'd3;

  localparam logic [2:0] DISP_MENU   = 3'd0;
  localparam logic [2:0] DISP_DEAL   = 3'd1;
  localparam logic [2:0] DISP_PLAYER = 3'd2;
  localparam logic [2:0] DISP_DEALER = 3'd3;
  localparam logic [2:0] DISP_RESULT = 3'd4;

  typedef enum logic [2:0] {
    S_MENU, S_CLR, S_DEAL_REQ, S_DEAL_WAIT, S_SETTLE, S_PLAYER, S_DEALER, S_RESULT
  } fsm_t;

  // Why the current card is being dealt; decides where SETTLE returns to.
  typedef enum logic [1:0] {
    K_INIT, K_HIT, K_DRAW
  } kind_t;

  fsm_t          fsm_q, fsm_d;
  kind_t         kind_q, kind_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          vblnk_q;
  logic          btn_start_q, btn_hit_q, btn_stand_q;
  logic          start_ev_q, start_ev_d;
  logic          hit_ev_q, hit_ev_d;
  logic          stand_ev_q, stand_ev_d;
  logic          deal_req_q, deal_req_d;
  logic          tgt_q, tgt_d;
  logic          hand_clr_q, hand_clr_d;
  logic [2:0]    state_q, state_d;
  logic [1:0]    result_q, result_d;

  logic          frame_tick;
  logic          fsm_change;
  logic [2:0]    disp;

  assign frame_tick = vblnk & ~vblnk_q;
  assign fsm_change = (fsm_d != fsm_q);

  always_comb begin
    fsm_d    = fsm_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    result_d = result_q;
    case (fsm_q)
      S_MENU: begin
        result_d = RES_NONE;
        if (start_ev_q) begin
          kind_d = K_INIT;
          fsm_d  = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d = 2'd0;
        tgt_d = 1'b0;
        fsm_d = S_DEAL_REQ;
      end
      S_DEAL_REQ: begin
        fsm_d = deal_ack ? S_SETTLE : S_DEAL_WAIT;
      end
      S_DEAL_WAIT: begin
        if (deal_ack) fsm_d = S_SETTLE;
      end
      S_SETTLE: begin
        case (kind_q)
          K_INIT: begin
            if (cnt_q != 2'd3) begin
              cnt_d = cnt_q + 2'd1;
              tgt_d = ~cnt_q[0];
              fsm_d = S_DEAL_REQ;
            end else begin
              fsm_d = S_PLAYER;
            end
          end
          K_HIT:   fsm_d = S_PLAYER;
          default: fsm_d = S_DEALER;
        endcase
      end
      S_PLAYER: begin
        if (player_sum > BLACKJACK) begin
          result_d = RES_LOSE;
          fsm_d    = S_RESULT;
        end else if (player_sum == BLACKJACK) begin
          fsm_d = S_DEALER;
        end else if (hit_ev_q) begin
          kind_d = K_HIT;
          tgt_d  = 1'b0;
          fsm_d  = S_DEAL_REQ;
        end else if (stand_ev_q) begin
          fsm_d = S_DEALER;
        end
      end
      S_DEALER: begin
        if (dealer_sum < STAND_SUM) begin
          kind_d = K_DRAW;
          tgt_d  = 1'b1;
          fsm_d  = S_DEAL_REQ;
        end else begin
          fsm_d = S_RESULT;
          if (dealer_sum > BLACKJACK || player_sum > dealer_sum) result_d = RES_WIN;
          else if (player_sum == dealer_sum)                     result_d = RES_PUSH;
          else                                                    result_d = RES_LOSE;
        end
      end
      S_RESULT: begin
        if (start_ev_q || frame_cnt_q == FRAMES_END) begin
          result_d = RES_NONE;
          fsm_d    = S_MENU;
        end
      end
      default: begin
        fsm_d = S_MENU;
      end
    endcase
  end

  // Sticky button flags; any FSM transition discards whatever is pending.
  always_comb begin
    start_ev_d = 1'b0;
    hit_ev_d   = 1'b0;
    stand_ev_d = 1'b0;
    if (!fsm_change) begin
      start_ev_d = start_ev_q | (btn_start & ~btn_start_q);
      hit_ev_d   = hit_ev_q   | (btn_hit   & ~btn_hit_q);
      stand_ev_d = stand_ev_q | (btn_stand & ~btn_stand_q);
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fsm_d == S_RESULT && fsm_q != S_RESULT) begin
      frame_cnt_d = '0;
    end else if (fsm_q == S_RESULT && frame_tick && frame_cnt_q != FRAMES_END) begin
      frame_cnt_d = frame_cnt_q + FW'(1);
    end
  end

  always_comb begin
    disp = DISP_MENU;
    case (fsm_q)
      S_MENU:   disp = DISP_MENU;
      S_PLAYER: disp = DISP_PLAYER;
      S_DEALER: disp = DISP_DEALER;
      S_RESULT: disp = DISP_RESULT;
      default: begin
        case (kind_q)
          K_INIT:  disp = DISP_DEAL;
          K_HIT:   disp = DISP_PLAYER;
          default: disp = DISP_DEALER;
        endcase
      end
    endcase
  end

  // Handshake outputs are registered from the next FSM state so they line up with it.
  always_comb begin
    deal_req_d = (fsm_d == S_DEAL_REQ) || (fsm_d == S_DEAL_WAIT);
    hand_clr_d = (fsm_d == S_CLR);
    state_d    = frame_tick ? disp : state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_MENU;
      kind_q      <= K_INIT;
      cnt_q       <= 2'd0;
      frame_cnt_q <= '0;
      vblnk_q     <= 1'b0;
      btn_start_q <= 1'b0;
      btn_hit_q   <= 1'b0;
      btn_stand_q <= 1'b0;
      start_ev_q  <= 1'b0;
      hit_ev_q    <= 1'b0;
      stand_ev_q  <= 1'b0;
      deal_req_q  <= 1'b0;
      tgt_q       <= 1'b0;
      hand_clr_q  <= 1'b0;
      state_q     <= DISP_MENU;
      result_q    <= RES_NONE;
    end else begin
      fsm_q       <= fsm_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vblnk_q     <= vblnk;
      btn_start_q <= btn_start;
      btn_hit_q   <= btn_hit;
      btn_stand_q <= btn_stand;
      start_ev_q  <= start_ev_d;
      hit_ev_q    <= hit_ev_d;
      stand_ev_q  <= stand_ev_d;
      deal_req_q  <= deal_req_d;
      tgt_q       <= tgt_d;
      hand_clr_q  <= hand_clr_d;
      state_q     <= state_d;
      result_q    <= result_d;
    end
  end

  assign deal_req       = deal_req_q;
  assign deal_to_dealer = tgt_q;
  assign hand_clr       = hand_clr_q;
  assign state          = state_q;
  assign result         = result_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - Scoreboard bench for game_ctrl with a card-level blackjack model
module tb_game_ctrl;

  localparam int RF    = 3;
  localparam int FRAME = 32;
  localparam int A_HIT   = 1;
  localparam int A_STAND = 2;
  localparam int A_BOTH  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_hit = 1'b0;
  logic       btn_stand = 1'b0;
  logic [4:0] player_sum = 5'd0;
  logic [4:0] dealer_sum = 5'd0;
  logic       deal_ack;
  logic       deal_req;
  logic       deal_to_dealer;
  logic       hand_clr;
  logic [2:0] state;
  logic [1:0] result;

  logic ack_r = 1'b0;
  logic eager = 1'b0;
  logic stray = 1'b0;
  assign deal_ack = ack_r | (eager & deal_req) | stray;

  game_ctrl #(.RESULT_FRAMES(RF), .DEALER_STAND(17)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .btn_start(btn_start), .btn_hit(btn_hit), .btn_stand(btn_stand),
    .player_sum(player_sum), .dealer_sum(dealer_sum),
    .deal_ack(deal_ack), .deal_req(deal_req), .deal_to_dealer(deal_to_dealer),
    .hand_clr(hand_clr), .state(state), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_tgt[$];
  int exp_res[$];
  int card_q[$];
  int force_cards[$];
  int force_acts[$];
  int acts[$];
  int delivered = 0;
  int hclr_seen = 0;
  int psum = 0;
  int dsum = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  initial begin
    forever begin
      for (int i = 0; i < FRAME; i++) begin
        @(posedge clk); #1;
        vblnk = (i >= FRAME - 3);
      end
    end
  end

  // Deck/hand block: acks after 0..3 cycles (0 = same cycle as the request) and adds the queued card.
  initial begin
    bit fire, tgt, clr;
    int dly, c;
    dly = 1;
    forever begin
      @(negedge clk);
      fire = !rst && deal_req && deal_ack;
      tgt  = deal_to_dealer;
      clr  = !rst && hand_clr;
      @(posedge clk); #1;
      if (rst) begin
        ack_r = 1'b0;
        eager = 1'b0;
      end else if (fire) begin
        c = (card_q.size() > 0) ? card_q.pop_front() : 2;
        if (tgt) dsum = sat(dsum + c);
        else     psum = sat(psum + c);
        player_sum = 5'(psum);
        dealer_sum = 5'(dsum);
        delivered++;
        ack_r = 1'b0;
        dly   = $urandom_range(0, 3);
        eager = (dly == 0);
      end else if (deal_req && !ack_r && !eager) begin
        if (dly <= 1) ack_r = 1'b1;
        else dly--;
      end
      if (clr) begin
        psum = 0;
        dsum = 0;
        player_sum = 5'd0;
        dealer_sum = 5'd0;
      end
    end
  end

  initial begin
    logic [2:0] st_prev;
    bit req_prev, clr_prev, vb_prev, tick_prev, tick_now;
    st_prev = 3'd0; req_prev = 0; clr_prev = 0; vb_prev = 0; tick_prev = 0;
    forever begin
      @(negedge clk);
      tick_now = vblnk && !vb_prev;
      if (rst) begin
        st_prev  = 3'd0;
        req_prev = 0;
        clr_prev = 0;
      end else begin
        if (deal_req && !req_prev) begin
          if (exp_tgt.size() == 0) check("unexpected_deal_req", 1, 0);
          else check("deal_target", int'(deal_to_dealer), exp_tgt.pop_front());
        end
        if (hand_clr) begin
          if (clr_prev) check("hand_clr_width", 2, 1);
          else hclr_seen++;
        end
        if (state != st_prev) begin
          check("state_frame_sync", int'(tick_prev), 1);
          if (state == 3'd4) begin
            if (exp_res.size() == 0) check("unexpected_result_state", 1, 0);
            else check("result", int'(result), exp_res.pop_front());
          end
          if (state == 3'd0) check("result_cleared", int'(result), 0);
        end
        st_prev  = state;
        req_prev = deal_req;
        clr_prev = hand_clr;
      end
      tick_prev = tick_now;
      vb_prev   = vblnk;
    end
  end

  task automatic draw(output int c);
    if (force_cards.size() > 0) c = force_cards.pop_front();
    else c = $urandom_range(1, 11);
    card_q.push_back(c);
  endtask

  // Plays the whole round on card values and queues the requests and verdict it implies.
  task automatic model_round();
    int p, d, c, a;
    bit bust, done;
    p = 0; d = 0; bust = 0; done = 0;
    for (int i = 0; i < 4; i++) begin
      draw(c);
      exp_tgt.push_back(i % 2);
      if (i % 2 == 1) d = sat(d + c);
      else p = sat(p + c);
    end
    while (!done) begin
      if (p > 21) begin
        bust = 1;
        done = 1;
      end else if (p == 21) begin
        done = 1;
      end else begin
        if (force_acts.size() > 0) a = force_acts.pop_front();
        else if (p < 12) a = ($urandom_range(0, 3) == 0) ? A_BOTH : A_HIT;
        else if (p < 17 && $urandom_range(0, 1) == 1) a = A_HIT;
        else a = A_STAND;
        acts.push_back(a);
        if (a == A_STAND) begin
          done = 1;
        end else begin
          draw(c);
          exp_tgt.push_back(0);
          p = sat(p + c);
        end
      end
    end
    if (bust) begin
      exp_res.push_back(2);
    end else begin
      while (d < 17) begin
        draw(c);
        exp_tgt.push_back(1);
        d = sat(d + c);
      end
      if (d > 21 || p > d) exp_res.push_back(1);
      else if (p == d)     exp_res.push_back(3);
      else                 exp_res.push_back(2);
    end
  endtask

  task automatic press(input bit s, input bit h, input bit t);
    @(posedge clk); #1;
    btn_start = s; btn_hit = h; btn_stand = t;
    repeat (2) @(posedge clk);
    #1;
    btn_start = 0; btn_hit = 0; btn_stand = 0;
  endtask

  task automatic wait_deliv(input int n);
    int k;
    k = 0;
    while (delivered < n && k < 300) begin
      @(posedge clk); #2;
      k++;
    end
    check("deal_progress", int'(delivered >= n), 1);
  endtask

  task automatic wait_state(input int s, input int bound, input string name);
    int k;
    k = 0;
    while (int'(state) != s && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(state), s);
  endtask

  task automatic run_round(input bit early);
    int need, a, hc0, ticks, k;
    bit vp;
    hc0 = hclr_seen;
    model_round();
    need = delivered + 4;
    press(1, 0, 0);
    while (acts.size() > 0) begin
      a = acts.pop_front();
      wait_deliv(need);
      repeat (4) @(posedge clk);
      case (a)
        A_HIT:   press(0, 1, 0);
        A_STAND: press(0, 0, 1);
        default: press(0, 1, 1);
      endcase
      if (a != A_STAND) need++;
    end
    wait_state(4, 40 * FRAME, "reach_result");
    check("hand_clr_pulses", hclr_seen, hc0 + 1);
    if (early) begin
      press(1, 0, 0);
      repeat (3 * FRAME) @(posedge clk);
      @(negedge clk);
      check("early_return_state", int'(state), 0);
      check("early_return_no_clr", hclr_seen, hc0 + 1);
      check("early_return_no_req", int'(deal_req), 0);
    end else begin
      ticks = 0; k = 0; vp = vblnk;
      while (state != 3'd0 && k < 10 * FRAME) begin
        @(negedge clk);
        k++;
        if (state != 3'd0 && vblnk && !vp) ticks++;
        vp = vblnk;
      end
      check("timeout_state", int'(state), 0);
      check("result_frames", ticks, RF);
    end
    check("requests_consumed", exp_tgt.size(), 0);
    check("cards_consumed", card_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hc0;
    #1 rst = 1'b1;
    #2;
    check("rst_state", int'(state), 0);
    check("rst_result", int'(result), 0);
    check("rst_deal_req", int'(deal_req), 0);
    check("rst_deal_to_dealer", int'(deal_to_dealer), 0);
    check("rst_hand_clr", int'(hand_clr), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);
    check("stray_ack_no_req", int'(deal_req), 0);
    check("idle_menu", int'(state), 0);

    force_cards = '{10, 9, 5, 8, 10};
    force_acts  = '{A_HIT};
    run_round(0);
    force_cards = '{10, 6, 8, 6, 10};
    force_acts  = '{A_STAND};
    run_round(1);
    force_cards = '{4, 10, 6, 9, 9};
    force_acts  = '{A_BOTH, A_STAND};
    run_round(0);
    for (int r = 0; r < 10; r++) run_round($urandom_range(0, 3) == 0);

    hc0 = hclr_seen;
    exp_tgt.push_back(0);
    card_q.push_back(5);
    press(1, 0, 0);
    k = 0;
    while (!deal_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reset_test_req_seen", int'(deal_req), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_deal_rst_req", int'(deal_req), 0);
    check("mid_deal_rst_state", int'(state), 0);
    check("mid_deal_rst_result", int'(result), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    card_q.delete();
    exp_tgt.delete();
    repeat (5 * FRAME) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle_state", int'(state), 0);
    check("post_rst_idle_req", int'(deal_req), 0);
    check("post_rst_no_clr", hclr_seen, hc0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
